// File: rtl/y_weight_filter.sv
`default_nettype none
// ============================================================================
// Module : y_weight_filter
// Three-stage Catmull-Rom vertical bicubic weighting with round, clamp,
// valid/ready flow control and a saturating clip-event counter.
// Rev    : 1.0
// ============================================================================
module y_weight_filter #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 7,
    parameter int CH     = 1,
    parameter int ROUND  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    phase,
    input  logic [CH*(DATA_W+FRAC_W)-1:0] in_0,
    input  logic [CH*(DATA_W+FRAC_W)-1:0] in_1,
    input  logic [CH*(DATA_W+FRAC_W)-1:0] in_2,
    input  logic [CH*(DATA_W+FRAC_W)-1:0] in_3,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH*DATA_W-1:0]          out_pix,
    output logic [15:0]                   sat_cnt
);
    localparam int IN_W  = DATA_W + FRAC_W;
    localparam int ACC_W = IN_W + 10;
    localparam int SHIFT = FRAC_W + 7;
    localparam logic signed [ACC_W-1:0] RND_BIAS =
        (ROUND != 0) ? ACC_W'(64'd1 << (SHIFT - 1)) : '0;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((64'd1 << DATA_W) - 64'd1);

    logic          en;
    logic          take;
    logic          v1;
    logic          v2;
    logic [CH-1:0] clip;

    // One global enable: the whole pipe freezes while the output is held.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign take     = in_valid && en;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [ACC_W-1:0] x0, x1, x2, x3;
        logic signed [ACC_W-1:0] m0, m1, m2, m3;
        logic signed [ACC_W-1:0] p0, p1, p2, p3;
        logic signed [ACC_W-1:0] sum, biased, r;
        logic [DATA_W-1:0]       pix_c, pix_q;
        logic                    clip_c;

        assign x0 = ACC_W'(in_0[c*IN_W +: IN_W]);
        assign x1 = ACC_W'(in_1[c*IN_W +: IN_W]);
        assign x2 = ACC_W'(in_2[c*IN_W +: IN_W]);
        assign x3 = ACC_W'(in_3[c*IN_W +: IN_W]);

        // Shift-add forms: 9=8+1, 111=128-16-1, 29=32-2-1, 3=2+1, 72=64+8.
        always_comb begin
            m0 = '0;
            m1 = '0;
            m2 = '0;
            m3 = '0;
            case (phase)
                2'd0: m1 = x1 <<< 7;
                2'd1: begin
                    m0 = -((x0 <<< 3) + x0);
                    m1 = (x1 <<< 7) - (x1 <<< 4) - x1;
                    m2 = (x2 <<< 5) - (x2 <<< 1) - x2;
                    m3 = -((x3 <<< 1) + x3);
                end
                2'd2: begin
                    m0 = -(x0 <<< 3);
                    m1 = (x1 <<< 6) + (x1 <<< 3);
                    m2 = (x2 <<< 6) + (x2 <<< 3);
                    m3 = -(x3 <<< 3);
                end
                default: begin
                    m0 = -((x0 <<< 1) + x0);
                    m1 = (x1 <<< 5) - (x1 <<< 1) - x1;
                    m2 = (x2 <<< 7) - (x2 <<< 4) - x2;
                    m3 = -((x3 <<< 3) + x3);
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                p0    <= '0;
                p1    <= '0;
                p2    <= '0;
                p3    <= '0;
                sum   <= '0;
                pix_q <= '0;
            end else if (en) begin
                if (take) begin
                    p0 <= m0;
                    p1 <= m1;
                    p2 <= m2;
                    p3 <= m3;
                end
                if (v1) sum <= p0 + p1 + p2 + p3;
                if (v2) pix_q <= pix_c;
            end
        end

        assign biased = sum + RND_BIAS;
        assign r      = biased >>> SHIFT;

        always_comb begin
            pix_c  = r[DATA_W-1:0];
            clip_c = 1'b0;
            if (r < 0) begin
                pix_c  = '0;
                clip_c = 1'b1;
            end else if (r > PIX_MAX) begin
                pix_c  = '1;
                clip_c = 1'b1;
            end
        end

        assign clip[c]                    = clip_c;
        assign out_pix[c*DATA_W +: DATA_W] = pix_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            sat_cnt   <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (v2 && (|clip) && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
        end
    end
endmodule
`default_nettype wire
